// File: rtl/assoc_set_engine.sv
// One N-way set-associative cache set with its own miss engine: tag compare,
// byte-enable writes, LRU/FIFO/random replacement, write-back and word refill.
module assoc_set_engine #(
  parameter int TAG_WIDTH    = 22,
  parameter int OFFSET_WIDTH = 5,
  parameter int SET_SIZE     = 4,
  parameter int POLICY       = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_byte_en_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic        mem_req_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int WORDS = 1 << (OFFSET_WIDTH - 2);
  localparam int BW    = OFFSET_WIDTH - 2;
  localparam int SEL   = $clog2(SET_SIZE);

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, RF_REQ, RF_WAIT} state_t;

  state_t               state_q;
  logic                 write_q;
  logic [31:2]          addr_q;
  logic [31:0]          wdata_q;
  logic [3:0]           be_q;
  logic [SEL-1:0]       victim_q;
  logic [BW-1:0]        beat_q;
  logic [SEL-1:0]       fifo_q;
  logic [15:0]          lfsr_q;
  logic [SET_SIZE-1:0]  valid_q;
  logic [SET_SIZE-1:0]  dirty_q;
  logic [TAG_WIDTH-1:0] tag_q  [SET_SIZE];
  logic [SEL-1:0]       age_q  [SET_SIZE];
  logic [31:0]          data_q [SET_SIZE][WORDS];

  logic [TAG_WIDTH-1:0] lookup_tag_s;
  logic [BW-1:0]        word_idx_s;
  logic                 hit_s;
  logic [SEL-1:0]       hit_way_s;
  logic [31:0]          hit_word_s;
  logic [31:0]          merged_s;
  logic [SEL-1:0]       victim_s;
  logic                 last_beat_s;
  logic                 addr_lsb_unused;

  assign lookup_tag_s    = addr_q[31:32-TAG_WIDTH];
  assign word_idx_s      = addr_q[OFFSET_WIDTH-1:2];
  assign last_beat_s     = (beat_q == BW'(WORDS - 1));
  assign addr_lsb_unused = ^req_addr_i[1:0];
  assign req_ready_o     = (state_q == IDLE);

  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = '0;
    for (int i = 0; i < SET_SIZE; i++) begin
      if (!hit_s && valid_q[i] && (tag_q[i] == lookup_tag_s)) begin
        hit_s     = 1'b1;
        hit_way_s = SEL'(i);
      end
    end
    hit_word_s = data_q[hit_way_s][word_idx_s];
    for (int b = 0; b < 4; b++) begin
      merged_s[8*b +: 8] = be_q[b] ? wdata_q[8*b +: 8] : hit_word_s[8*b +: 8];
    end
  end

  // Invalid ways take precedence over the replacement policy.
  always_comb begin
    logic           found;
    logic [SEL-1:0] lru_way;
    logic [SEL-1:0] max_age;
    lru_way = '0;
    max_age = age_q[0];
    for (int i = 1; i < SET_SIZE; i++) begin
      if (age_q[i] > max_age) begin
        max_age = age_q[i];
        lru_way = SEL'(i);
      end
    end
    case (POLICY)
      0:       victim_s = lru_way;
      1:       victim_s = fifo_q;
      default: victim_s = lfsr_q[SEL-1:0];
    endcase
    found = 1'b0;
    for (int i = 0; i < SET_SIZE; i++) begin
      if (!found && !valid_q[i]) begin
        found    = 1'b1;
        victim_s = SEL'(i);
      end
    end
  end

  always_comb begin
    resp_valid_o = 1'b0;
    resp_rdata_o = 32'h0;
    if (state_q == LOOKUP && hit_s) begin
      resp_valid_o = 1'b1;
      resp_rdata_o = write_q ? merged_s : hit_word_s;
    end else begin
      resp_valid_o = 1'b0;
    end
  end

  always_comb begin
    mem_req_valid_o = 1'b0;
    mem_req_write_o = 1'b0;
    mem_addr_o      = 32'h0;
    mem_wdata_o     = 32'h0;
    case (state_q)
      WB: begin
        mem_req_valid_o = 1'b1;
        mem_req_write_o = 1'b1;
        mem_addr_o      = {tag_q[victim_q], addr_q[31-TAG_WIDTH:OFFSET_WIDTH], beat_q, 2'b00};
        mem_wdata_o     = data_q[victim_q][beat_q];
      end
      RF_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = {addr_q[31:OFFSET_WIDTH], beat_q, 2'b00};
      end
      default: mem_req_valid_o = 1'b0;
    endcase
  end

  // Control FSM with tag, valid/dirty and replacement state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      be_q     <= 4'h0;
      victim_q <= '0;
      beat_q   <= '0;
      fifo_q   <= '0;
      lfsr_q   <= 16'hACE1;
      valid_q  <= '0;
      dirty_q  <= '0;
      for (int i = 0; i < SET_SIZE; i++) begin
        tag_q[i] <= '0;
        age_q[i] <= SEL'(i);
      end
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            write_q <= req_write_i;
            addr_q  <= req_addr_i[31:2];
            wdata_q <= req_wdata_i;
            be_q    <= req_byte_en_i;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit_s) begin
            if (write_q && (be_q != 4'h0)) dirty_q[hit_way_s] <= 1'b1;
            if (POLICY == 0) begin
              for (int i = 0; i < SET_SIZE; i++) begin
                if (SEL'(i) == hit_way_s) age_q[i] <= '0;
                else if (age_q[i] < age_q[hit_way_s]) age_q[i] <= age_q[i] + SEL'(1);
              end
            end
            state_q <= IDLE;
          end else begin
            victim_q <= victim_s;
            beat_q   <= '0;
            state_q  <= (valid_q[victim_s] && dirty_q[victim_s]) ? WB : RF_REQ;
          end
        end
        WB: begin
          if (mem_req_ready_i) begin
            beat_q <= last_beat_s ? '0 : beat_q + BW'(1);
            if (last_beat_s) state_q <= RF_REQ;
          end
        end
        RF_REQ: begin
          if (mem_req_ready_i) state_q <= RF_WAIT;
        end
        RF_WAIT: begin
          if (mem_rvalid_i) begin
            if (last_beat_s) begin
              tag_q[victim_q]   <= lookup_tag_s;
              valid_q[victim_q] <= 1'b1;
              dirty_q[victim_q] <= 1'b0;
              fifo_q            <= fifo_q + SEL'(1);
              beat_q            <= '0;
              state_q           <= LOOKUP;
            end else begin
              beat_q  <= beat_q + BW'(1);
              state_q <= RF_REQ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (state_q == LOOKUP && hit_s && write_q) data_q[hit_way_s][word_idx_s] <= merged_s;
    if (state_q == RF_WAIT && mem_rvalid_i) data_q[victim_q][beat_q] <= mem_rdata_i;
  end

endmodule

// File: tb/tb_assoc_set_engine.sv
// Directed bench for assoc_set_engine: vector table plus back-pressure and
// mid-burst reset sequences against a small memory model.
module tb_assoc_set_engine;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_byte_en_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        mem_req_valid_o, mem_req_ready_i, mem_req_write_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  assoc_set_engine dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_byte_en_i(req_byte_en_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_write_o(mem_req_write_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_rst;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    int          exp_wb;
    int          exp_rd;
    logic [31:0] exp_wb_base;
    logic [31:0] exp_rd_base;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [31:0] wb_a[$], wb_d[$], rd_a[$];
  logic [31:0] mem_img [logic [31:0]];
  logic [31:0] shadow  [logic [31:0]];
  int  rv_cnt = 0;
  bit  stall_en = 1'b0;
  int  stall_left = 0;
  vec_t vecs [18];

  // Untouched memory: line 0x1000 holds 0xA0+i, each further 32-byte line adds 0x100.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((({21'h0, a[15:5]}) - 32'h80) << 8) | (32'hA0 + {29'h0, a[4:2]});
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem_img.exists(a) ? mem_img[a] : mem_word(a);
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : mem_read(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model: drives ready/rvalid on the falling edge, logs handshakes.
  initial begin
    logic        pend;
    logic [31:0] pend_addr;
    pend = 1'b0;
    pend_addr = 32'h0;
    mem_req_ready_i = 1'b1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      if (rst_i) begin
        pend = 1'b0;
      end else if (pend) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_read(pend_addr);
        pend = 1'b0;
        rv_cnt++;
      end
      if (stall_en && stall_left > 0 && mem_req_valid_o && mem_req_write_o && wb_a.size() == 2) begin
        mem_req_ready_i = 1'b0;
        stall_left--;
        chk("stall_addr", mem_addr_o, 32'h1408);
        chk("stall_wdata", mem_wdata_o, exp_word(32'h1408));
      end else begin
        mem_req_ready_i = 1'b1;
      end
      if (!rst_i && mem_req_valid_o && mem_req_ready_i) begin
        if (mem_req_write_o) begin
          wb_a.push_back(mem_addr_o);
          wb_d.push_back(mem_wdata_o);
          mem_img[mem_addr_o] = mem_wdata_o;
        end else begin
          rd_a.push_back(mem_addr_o);
          pend = 1'b1;
          pend_addr = mem_addr_o;
        end
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #2 rst_i = 1'b1;
    @(posedge clk); @(posedge clk); #2 rst_i = 1'b0;
    shadow.delete();
    @(negedge clk);
  endtask

  task automatic do_req(input vec_t v, input string nm);
    logic [31:0] rdata;
    int lat;
    bit got;
    if (v.do_rst) apply_reset();
    wb_a.delete(); wb_d.delete(); rd_a.delete();
    req_write_i = v.wr; req_addr_i = v.addr; req_wdata_i = v.wdata;
    req_byte_en_i = v.be; req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    lat = 1; got = 1'b0; rdata = 32'h0;
    while (!got && lat < 300) begin
      if (resp_valid_o) begin
        got = 1'b1;
        rdata = resp_rdata_o;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s timeout: no response after %0d cycles, expected %h", nm, lat, v.exp_rdata);
    end else begin
      @(negedge clk);
      chk({nm, "_rdata"}, rdata, v.exp_rdata);
      chk({nm, "_wb_beats"}, 32'(wb_a.size()), 32'(v.exp_wb));
      chk({nm, "_rd_beats"}, 32'(rd_a.size()), 32'(v.exp_rd));
      for (int i = 0; i < wb_a.size() && i < v.exp_wb; i++) begin
        chk({nm, "_wb_addr"}, wb_a[i], v.exp_wb_base + 32'(4 * i));
        chk({nm, "_wb_data"}, wb_d[i], exp_word(v.exp_wb_base + 32'(4 * i)));
      end
      for (int i = 0; i < rd_a.size() && i < v.exp_rd; i++)
        chk({nm, "_rd_addr"}, rd_a[i], v.exp_rd_base + 32'(4 * i));
      if (v.exp_rd == 0 && v.exp_wb == 0) chk({nm, "_latency"}, 32'(lat), 32'd1);
      if (v.wr) shadow[{v.addr[31:2], 2'b00}] = v.exp_rdata;
    end
  endtask

  initial begin
    vec_t hv;
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = 32'h0;
    req_wdata_i = 32'h0; req_byte_en_i = 4'h0;

    //        rst   wr    addr        wdata         be    rdata        wb rd wb_base      rd_base
    vecs[0]  = '{1'b0, 1'b0, 32'h1004, 32'h0,        4'h0, 32'h000000A1, 0, 8, 32'h0,    32'h1000};
    vecs[1]  = '{1'b0, 1'b0, 32'h1008, 32'h0,        4'h0, 32'h000000A2, 0, 0, 32'h0,    32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'h1004, 32'hDEADBEEF, 4'h3, 32'h0000BEEF, 0, 0, 32'h0,    32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h1004, 32'h0,        4'h0, 32'h0000BEEF, 0, 0, 32'h0,    32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h1400, 32'h0,        4'h0, 32'h000020A0, 0, 8, 32'h0,    32'h1400};
    vecs[5]  = '{1'b0, 1'b0, 32'h1800, 32'h0,        4'h0, 32'h000040A0, 0, 8, 32'h0,    32'h1800};
    vecs[6]  = '{1'b0, 1'b0, 32'h1C00, 32'h0,        4'h0, 32'h000060A0, 0, 8, 32'h0,    32'h1C00};
    vecs[7]  = '{1'b0, 1'b0, 32'h1000, 32'h0,        4'h0, 32'h000000A0, 0, 0, 32'h0,    32'h0};
    vecs[8]  = '{1'b0, 1'b0, 32'h2000, 32'h0,        4'h0, 32'h000080A0, 0, 8, 32'h0,    32'h2000};
    vecs[9]  = '{1'b0, 1'b0, 32'h1800, 32'h0,        4'h0, 32'h000040A0, 0, 0, 32'h0,    32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h1400, 32'h0,        4'h0, 32'h000020A0, 0, 8, 32'h0,    32'h1400};
    vecs[11] = '{1'b0, 1'b0, 32'h1C00, 32'h0,        4'h0, 32'h000060A0, 8, 8, 32'h1000, 32'h1C00};
    vecs[12] = '{1'b1, 1'b1, 32'h1400, 32'h12345678, 4'hF, 32'h12345678, 0, 8, 32'h0,    32'h1400};
    vecs[13] = '{1'b0, 1'b0, 32'h1000, 32'h0,        4'h0, 32'h000000A0, 0, 8, 32'h0,    32'h1000};
    vecs[14] = '{1'b0, 1'b0, 32'h1400, 32'h0,        4'h0, 32'h12345678, 0, 0, 32'h0,    32'h0};
    vecs[15] = '{1'b0, 1'b0, 32'h1800, 32'h0,        4'h0, 32'h000040A0, 0, 8, 32'h0,    32'h1800};
    vecs[16] = '{1'b0, 1'b0, 32'h1C00, 32'h0,        4'h0, 32'h000060A0, 0, 8, 32'h0,    32'h1C00};
    vecs[17] = '{1'b0, 1'b0, 32'h1000, 32'h0,        4'h0, 32'h000000A0, 0, 0, 32'h0,    32'h0};

    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_mem_valid", 32'(mem_req_valid_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    @(posedge clk); #2 rst_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 18; i++) do_req(vecs[i], $sformatf("vec%0d", i));

    // Dirty 0x1400 line evicted by 0x2000 with ready held low on beat 2.
    stall_en = 1'b1; stall_left = 3;
    hv = '{1'b0, 1'b0, 32'h2000, 32'h0, 4'h0, 32'h000080A0, 8, 8, 32'h1400, 32'h2000};
    do_req(hv, "backpressure");
    chk("stall_cycles_seen", 32'(stall_left), 32'd0);
    stall_en = 1'b0;

    // Reset in the middle of a refill burst.
    begin
      int base;
      int n;
      wb_a.delete(); wb_d.delete(); rd_a.delete();
      base = rv_cnt;
      req_write_i = 1'b0; req_addr_i = 32'h3004; req_byte_en_i = 4'h0; req_valid_i = 1'b1;
      @(negedge clk);
      req_valid_i = 1'b0;
      n = 0;
      while ((rv_cnt - base) < 3 && n < 200) begin @(negedge clk); n++; end
      while (!mem_req_valid_o && n < 200) begin @(negedge clk); n++; end
      chk("pre_rst_mem_valid", 32'(mem_req_valid_o), 32'd1);
      #2 rst_i = 1'b1;
      #1;
      chk("mid_rst_mem_valid", 32'(mem_req_valid_o), 32'd0);
      chk("mid_rst_req_ready", 32'(req_ready_o), 32'd1);
      chk("mid_rst_resp_valid", 32'(resp_valid_o), 32'd0);
      @(posedge clk); @(posedge clk); #2 rst_i = 1'b0;
      shadow.delete();
      @(negedge clk);
    end
    hv = '{1'b0, 1'b0, 32'h3004, 32'h0, 4'h0, 32'h000100A1, 0, 8, 32'h0, 32'h3000};
    do_req(hv, "post_rst_reread");
    hv = '{1'b0, 1'b0, 32'h1400, 32'h0, 4'h0, 32'h12345678, 0, 8, 32'h0, 32'h1400};
    do_req(hv, "post_rst_wb_line");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
